// File: rtl/elastic_fifo_pkg.sv
// Shared constants and width helpers for the elastic FIFO.
// Pointer and count widths are derived here so every file agrees.
package elastic_fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/elastic_fifo_ex_dpram.sv
// Simple dual-port storage: one synchronous write port, one async read.
// Contents are deliberately left unreset.
module fifo_dpram
  import elastic_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_fifo_ex.sv
// Elastic FIFO with occupancy flags, sticky errors and optional
// first-word fall-through presentation of the head word.
module elastic_fifo_ex
  import elastic_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int MODE     = MODE_STD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   dout_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] rdata;
  logic             rd_acc;
  logic             wr_acc;

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // FWFT shows the head word live; standard mode shows the read register.
  assign data_out   = (MODE == MODE_FWFT) ? rdata  : dout_q;
  assign dout_valid = (MODE == MODE_FWFT) ? !empty : dvalid_q;

  always_comb begin
    rd_acc = !flush && rd_en && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    wr_acc = !flush && wr_en && (!full || rd_acc);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        dout_d   = rdata;
        dvalid_d = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    ovf_d = (ovf_q && !clr_err) || (!flush && wr_en && !wr_acc);
    unf_d = (unf_q && !clr_err) || (!flush && rd_en && !rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_elastic_fifo_ex.sv
// Bench for elastic_fifo_ex: standard and FWFT instances side by side,
// checked against a queue-based model of the FIFO.
module tb_elastic_fifo_ex;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] d0, d1;
  logic       v0, e0, f0, ae0, af0, ov0, un0;
  logic       v1, e1, f1, ae1, af1, ov1, un1;
  logic [3:0] c0, c1;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_valid;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  elastic_fifo_ex #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .clr_err(clr_err), .data_in(din), .data_out(d0), .dout_valid(v0),
    .empty(e0), .full(f0), .almost_empty(ae0), .almost_full(af0),
    .count(c0), .overflow(ov0), .underflow(un0));

  elastic_fifo_ex #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .clr_err(clr_err), .data_in(din), .data_out(d1), .dout_valid(v1),
    .empty(e1), .full(f1), .almost_empty(ae1), .almost_full(af1),
    .count(c1), .overflow(ov1), .underflow(un1));

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_valid = 1'b0;
    m_dout = '0;
  endtask

  // Drive one clock cycle and advance the model by the FIFO rules.
  task automatic cyc(input logic w, input logic r, input logic f,
                     input logic c, input logic [7:0] d);
    bit rd_ok, wr_ok;
    wr_en = w; rd_en = r; flush = f; clr_err = c; din = d;
    @(posedge clk);
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (f) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < D) || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    m_ovf = (m_ovf && !c) || (w && !f && !wr_ok);
    m_unf = (m_unf && !c) || (r && !f && !rd_ok);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (c0 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", c0); end
    checks++; if ({e0, ae0, f0, af0} !== 4'b1100) begin failures++; $display("FAIL reset_flags got=%b exp=1100", {e0, ae0, f0, af0}); end
    checks++; if ({d0, v0, ov0, un0} !== 11'd0) begin failures++; $display("FAIL reset_out got=%h/%b/%b/%b exp=0", d0, v0, ov0, un0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h11 + 8'(i));
    checks++; if ({f0, c0} !== {1'b1, 4'd8}) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/8", f0, c0); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      checks++;
      if ({v0, d0} !== {1'b1, 8'h11 + 8'(i)}) begin
        failures++; $display("FAIL drain_data%0d got=%b/%h exp=1/%h", i, v0, d0, 8'h11 + 8'(i));
      end
    end
    cyc(0, 0, 0, 0, 8'h00);
    checks++; if ({v0, e0, ov0, un0} !== 4'b0100) begin failures++; $display("FAIL drain_end got=%b exp=0100", {v0, e0, ov0, un0}); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'($urandom));
    cyc(1, 1, 0, 0, 8'hAA);
    checks++; if ({c0, ov0} !== {4'd8, 1'b0}) begin failures++; $display("FAIL full_rw got=%0d/%b exp=8/0", c0, ov0); end
    checks++; if (d0 !== m_dout) begin failures++; $display("FAIL full_rw_head got=%h exp=%h", d0, m_dout); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      checks++; if ({v0, d0} !== {1'b1, m_dout}) begin failures++; $display("FAIL full_rw_drain%0d got=%h exp=%h", i, d0, m_dout); end
    end
    checks++; if ({d0, e0} !== {8'hAA, 1'b1}) begin failures++; $display("FAIL full_rw_last got=%h/%b exp=aa/1", d0, e0); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h60 + 8'(i));
    cyc(1, 0, 0, 0, 8'h77);
    checks++; if ({ov0, c0} !== {1'b1, 4'd8}) begin failures++; $display("FAIL ovf_set got=%b/%0d exp=1/8", ov0, c0); end
    cyc(0, 0, 0, 1, 8'h00);
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ov0); end
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'h00);
    checks++; if (d0 !== 8'h67) begin failures++; $display("FAIL ovf_nowrite got=%h exp=67", d0); end
    cyc(0, 1, 0, 0, 8'h00);
    checks++; if ({un0, ov0} !== 2'b10) begin failures++; $display("FAIL unf_set got=%b%b exp=10", un0, ov0); end
    cyc(0, 1, 0, 1, 8'h00);
    checks++; if (un0 !== 1'b1) begin failures++; $display("FAIL unf_clr_coincide got=%b exp=1", un0); end
    cyc(0, 0, 0, 1, 8'h00);
    checks++; if (un0 !== 1'b0) begin failures++; $display("FAIL unf_clr got=%b exp=0", un0); end
    cyc(1, 1, 0, 0, 8'h42);
    checks++; if ({c0, un0, v0} !== {4'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL empty_rw got=%0d/%b/%b exp=1/1/0", c0, un0, v0); end
    cyc(0, 1, 0, 1, 8'h00);
    checks++; if ({d0, un0, e0} !== {8'h42, 1'b0, 1'b1}) begin failures++; $display("FAIL empty_rw_data got=%h/%b/%b exp=42/0/1", d0, un0, e0); end
  endtask

  task automatic test_fwft();
    cyc(1, 0, 0, 0, 8'h5A);
    checks++; if ({d1, v1, e1} !== {8'h5A, 1'b1, 1'b0}) begin failures++; $display("FAIL fwft_present got=%h/%b/%b exp=5a/1/0", d1, v1, e1); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL std_no_early got=%b exp=0", v0); end
    cyc(0, 1, 0, 0, 8'h00);
    checks++; if ({v1, e1} !== 2'b01) begin failures++; $display("FAIL fwft_pop got=%b%b exp=01", v1, e1); end
    checks++; if ({v0, d0} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL std_after_pop got=%b/%h exp=1/5a", v0, d0); end
  endtask

  task automatic test_sweep_wrap();
    logic [7:0] val;
    for (int i = 0; i <= 8; i++) begin
      checks++;
      if ({c0, ae0, af0} !== {4'(i), i <= 2, i >= 6}) begin
        failures++; $display("FAIL sweep_up%0d got=%0d/%b/%b", i, c0, ae0, af0);
      end
      if (i < 8) cyc(1, 0, 0, 0, 8'(i));
    end
    for (int i = 8; i >= 0; i--) begin
      checks++;
      if ({c0, ae0, af0} !== {4'(i), i <= 2, i >= 6}) begin
        failures++; $display("FAIL sweep_dn%0d got=%0d/%b/%b", i, c0, ae0, af0);
      end
      if (i > 0) cyc(0, 1, 0, 0, 8'h00);
    end
    for (int k = 0; k < 20; k++) begin
      val = 8'h20 + 8'(k);
      cyc(1, 0, 0, 0, val);
      cyc(0, 1, 0, 0, 8'h00);
      checks++; if ({v0, d0} !== {1'b1, val}) begin failures++; $display("FAIL wrap%0d got=%h exp=%h", k, d0, val); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'h90 + 8'(i));
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h95);
    checks++; if (c0 !== 4'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", c0); end
    cyc(1, 1, 1, 0, 8'hEE);
    checks++; if ({c0, e0, v0} !== {4'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL flush got=%0d/%b/%b exp=0/1/0", c0, e0, v0); end
    checks++; if ({d0, ov0, un0} !== {8'h90, 2'b00}) begin failures++; $display("FAIL flush_keep got=%h/%b%b exp=90/00", d0, ov0, un0); end
    cyc(1, 0, 0, 0, 8'h33);
    checks++; if (d1 !== 8'h33) begin failures++; $display("FAIL flush_after got=%h exp=33", d1); end
    cyc(0, 1, 0, 0, 8'h00);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'hB0 + 8'(i));
    cyc(1, 1, 0, 0, 8'hB3);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hB4;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({c0, e0, ae0, f0, af0} !== {4'd0, 4'b1100}) begin failures++; $display("FAIL midrst_flags got=%0d/%b", c0, {e0, ae0, f0, af0}); end
    checks++; if ({d0, v0, ov0, un0, v1} !== 12'd0) begin failures++; $display("FAIL midrst_out got=%h/%b/%b/%b/%b exp=0", d0, v0, ov0, un0, v1); end
    wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 8'hC3);
    cyc(1, 0, 0, 0, 8'h3C);
    checks++; if (u0.u_mem.mem[0] !== 8'hC3) begin failures++; $display("FAIL midrst_addr0 got=%h exp=c3", u0.u_mem.mem[0]); end
    checks++; if ({d1, c1} !== {8'hC3, 4'd2}) begin failures++; $display("FAIL midrst_head got=%h/%0d exp=c3/2", d1, c1); end
  endtask

  task automatic test_random();
    logic w, r, f, c;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 3);
      c = ($urandom_range(0, 99) < 6);
      cyc(w, r, f, c, 8'($urandom));
      checks++;
      if (c0 !== 4'(q.size()) || c1 !== 4'(q.size())) begin
        failures++; $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d", n, c0, c1, q.size());
      end
      checks++;
      if ({e0, f0, ae0, af0} !== {q.size() == 0, q.size() == D, q.size() <= 2, q.size() >= 6}) begin
        failures++; $display("FAIL rnd_flags n=%0d got=%b size=%0d", n, {e0, f0, ae0, af0}, q.size());
      end
      checks++;
      if ({ov0, un0, ov1, un1} !== {m_ovf, m_unf, m_ovf, m_unf}) begin
        failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, {ov0, un0, ov1, un1}, {m_ovf, m_unf, m_ovf, m_unf});
      end
      checks++;
      if ({v0, d0} !== {m_valid, m_dout}) begin
        failures++; $display("FAIL rnd_std n=%0d got=%b/%h exp=%b/%h", n, v0, d0, m_valid, m_dout);
      end
      checks++;
      if (v1 !== (q.size() > 0) || (q.size() > 0 && d1 !== q[0])) begin
        failures++; $display("FAIL rnd_fwft n=%0d got=%b/%h size=%0d", n, v1, d1, q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_errors();
    test_fwft();
    test_sweep_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
